// File: rtl/act_quant_pkg.sv
// Shared defaults, types and int8 limits for the activation quantizer.
package act_quant_pkg;

    localparam int ACC_W_DEFAULT   = 24;
    localparam int FRAC_W_DEFAULT  = 10;
    localparam int VEC_LEN_DEFAULT = 16;

    typedef logic [2:0]        scale_t;
    typedef logic signed [7:0] q8_t;

    typedef enum logic [1:0] {
        COLLECT,
        SCALE,
        EMIT
    } state_t;

    localparam q8_t Q8_MAX = q8_t'(127);
    localparam q8_t Q8_MIN = q8_t'(-128);

endpackage

// File: rtl/act_quant_round_sat.sv
// Combinational round-half-up arithmetic right shift of one accumulator word,
// saturated to int8; sat flags a clamped result.
module act_quant_round_sat
    import act_quant_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT,
    parameter int SH_W  = 4
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic        [SH_W-1:0]  sh,
    output q8_t                     q,
    output logic                    sat
);

    localparam int EW = ACC_W + 1;
    localparam logic signed [EW-1:0] HI = EW'(Q8_MAX);
    localparam logic signed [EW-1:0] LO = EW'(Q8_MIN);

    logic signed [EW-1:0] bias;
    logic signed [EW-1:0] sum;
    logic signed [EW-1:0] shifted;

    always_comb begin
        bias = '0;
        if (sh != '0) begin
            bias = EW'(1) << (sh - SH_W'(1));
        end
        // One guard bit above the accumulator keeps a + bias from wrapping.
        sum     = EW'(a) + bias;
        shifted = sum >>> sh;
        q       = shifted[7:0];
        sat     = 1'b0;
        if (shifted > HI) begin
            q   = Q8_MAX;
            sat = 1'b1;
        end else if (shifted < LO) begin
            q   = Q8_MIN;
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/act_quant_tx.sv
// Dynamic power-of-two activation quantizer: buffers one vector, picks a shared
// scale, then streams int8 + scale. ACTQ_SCALE_OVERRIDE_EN adds a forced-scale port pair.
module act_quant_tx
    import act_quant_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEFAULT,
    parameter int FRAC_W  = FRAC_W_DEFAULT,
    parameter int VEC_LEN = VEC_LEN_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef ACTQ_SCALE_OVERRIDE_EN
    input  logic                    cfg_override,
    input  logic [2:0]              cfg_scale,
`endif
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [ACC_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [7:0]       out_data,
    output logic [2:0]              out_scale,
    output logic                    out_last,
    output logic                    sat_flag
);

    localparam int CNT_W = $clog2(VEC_LEN);
    localparam int SH_W  = $clog2(FRAC_W + 1);
    localparam int BW    = ((ACC_W > FRAC_W + 8) ? ACC_W : FRAC_W + 8) + 2;
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(VEC_LEN - 1);
    localparam logic [ACC_W-1:0] MAG_LIMIT = ACC_W'(Q8_MAX);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] max_val_q, max_val_d;
    logic signed [ACC_W-1:0] min_val_q, min_val_d;
    scale_t                  sel_scale_q, sel_scale_d;
    logic                    sat_q, sat_d;
    logic signed [ACC_W-1:0] buf_q [VEC_LEN];

    logic                    in_fire, out_fire, is_last;
    logic [ACC_W-1:0]        min_mag, max_abs;
    scale_t                  auto_scale, pick_scale;
    logic [SH_W-1:0]         pick_sh, emit_sh;
    logic signed [BW-1:0]    half_w, lim_w, hi_sum, lo_sum;
    logic                    sat_pick;
    logic signed [ACC_W-1:0] emit_a;
    q8_t                     emit_q;
    logic                    emit_sat;

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == EMIT);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign is_last   = (cnt_q == LAST_IDX);

    // Signed max/min are tracked so the saturation test keeps the sign;
    // the most negative word negates to 2^(ACC_W-1) without wrapping as unsigned.
    assign min_mag = $unsigned(-min_val_q);
    assign max_abs = ($unsigned(max_val_q) > min_mag) ? $unsigned(max_val_q) : min_mag;

    always_comb begin
        auto_scale = '0;
        for (int s = 0; s < 8; s++) begin
            if ((max_abs >> (FRAC_W - s)) <= MAG_LIMIT) begin
                auto_scale = scale_t'(s);
            end
        end
    end

`ifdef ACTQ_SCALE_OVERRIDE_EN
    assign pick_scale = cfg_override ? scale_t'(cfg_scale) : auto_scale;
`else
    assign pick_scale = auto_scale;
`endif

    assign pick_sh = SH_W'(FRAC_W) - SH_W'(pick_scale);
    assign emit_sh = SH_W'(FRAC_W) - SH_W'(sel_scale_q);

    // Rounding is monotonic, so only the extremes need testing against the bound.
    always_comb begin
        half_w = '0;
        if (pick_sh != '0) begin
            half_w = BW'(1) << (pick_sh - SH_W'(1));
        end
        lim_w    = BW'(-int'(Q8_MIN)) << pick_sh;
        hi_sum   = BW'(max_val_q) + half_w;
        lo_sum   = BW'(min_val_q) + half_w;
        sat_pick = (hi_sum >= lim_w) || (lo_sum < -lim_w);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        max_val_d   = max_val_q;
        min_val_d   = min_val_q;
        sel_scale_d = sel_scale_q;
        sat_d       = sat_q;
        case (state_q)
            COLLECT: begin
                if (in_fire) begin
                    if (in_data > max_val_q) max_val_d = in_data;
                    if (in_data < min_val_q) min_val_d = in_data;
                    if (is_last) begin
                        cnt_d   = '0;
                        state_d = SCALE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            SCALE: begin
                sel_scale_d = pick_scale;
                sat_d       = sat_pick;
                state_d     = EMIT;
            end
            EMIT: begin
                if (out_fire) begin
                    if (is_last) begin
                        state_d   = COLLECT;
                        cnt_d     = '0;
                        max_val_d = '0;
                        min_val_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            max_val_q   <= '0;
            min_val_q   <= '0;
            sel_scale_q <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            max_val_q   <= max_val_d;
            min_val_q   <= min_val_d;
            sel_scale_q <= sel_scale_d;
            sat_q       <= sat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            buf_q[cnt_q] <= in_data;
        end
    end

    assign emit_a = buf_q[cnt_q];

    act_quant_round_sat #(
        .ACC_W (ACC_W),
        .SH_W  (SH_W)
    ) u_round_sat (
        .a   (emit_a),
        .sh  (emit_sh),
        .q   (emit_q),
        .sat (emit_sat)
    );

    // Outputs are forced to zero outside EMIT so they read as reset values.
    // The live per-element flag is already implied by sat_q.
    assign out_data  = out_valid ? emit_q : '0;
    assign out_scale = out_valid ? sel_scale_q : '0;
    assign out_last  = out_valid & is_last;
    assign sat_flag  = out_valid & (sat_q | emit_sat);

endmodule
